// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: funct3 encodings, FSM states and lane width.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned LANE_W = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: store mask/data placement and load extraction with sign/zero extension.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rword,
  output logic [LANE_W-1:0] wmask,
  output logic [31:0]       wdata_sh,
  output logic [31:0]       rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rword[{addr_lo, 3'b000} +: 8];
    half_sel  = rword[{addr_lo[1], 4'b0000} +: 16];
    wmask     = '0;
    wdata_sh  = '0;
    rdata_ext = '0;
    // Store data is replicated across lanes; the mask picks which lanes land.
    case (funct3)
      F3_B: begin
        wmask     = 4'b0001 << addr_lo;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        wmask     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = {{16{half_sel[15]}}, half_sel};
      end
      F3_W: begin
        wmask     = 4'b1111;
        wdata_sh  = wdata;
        rdata_ext = rword;
      end
      F3_BU:   rdata_ext = {24'h0, byte_sel};
      F3_HU:   rdata_ext = {16'h0, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with fixed latency over valid/ready handshakes.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned H/W accesses fault instead of aligning down.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0]     idx;
  logic              in_range, f3_ok, is_h, is_w, misalign, acc_err, accept, commit;
  logic [1:0]        lane_lo;
  logic [LANE_W-1:0] wmask;
  logic [31:0]       wdata_sh, rdata_ext;

  always_comb begin
    idx      = addr_q[AW+1:2];
    in_range = (addr_q[31:AW+2] == '0);
    f3_ok    = we_q ? (f3_q inside {F3_B, F3_H, F3_W})
                    : (f3_q inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    is_h     = (f3_q[1:0] == 2'b01);
    is_w     = (f3_q[1:0] == 2'b10);
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = (is_h && addr_q[0]) || (is_w && (addr_q[1:0] != 2'b00));
    lane_lo  = addr_q[1:0];
`else
    misalign = 1'b0;
    lane_lo  = is_w ? 2'b00 : (is_h ? {addr_q[1], 1'b0} : addr_q[1:0]);
`endif
    acc_err  = !in_range || !f3_ok || misalign;
    accept   = (state_q == ST_IDLE) && ready_q && req_valid;
    commit   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  end

  dmem_lane u_lane (
    .funct3    (f3_q),
    .addr_lo   (lane_lo),
    .wdata     (wdata_q),
    .rword     (mem[idx]),
    .wmask     (wmask),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_IDLE);
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || we_q) ? 32'd0 : rdata_ext;
      end
    end
  end

  // Array is not reset; commit only happens out of WAIT, so a reset in WAIT drops the store.
  always_ff @(posedge clk) begin
    if (commit && we_q && !acc_err) begin
      for (int i = 0; i < LANE_W; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes model expectations, monitor pops on handshake.
module tb_dmem_responder;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          edge_n;
  } exp_t;
  exp_t sbq[$];

  bit [31:0] mdl [int];
  bit        bp_hold = 1'b0;

  always @(posedge clk) begin
    #1 resp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed access on a word array, computed from sizes and offsets.
  function automatic void model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                input bit [31:0] wdata, output bit [31:0] rdata,
                                output bit err);
    int        size;
    bit        sgn;
    bit        legal;
    bit [31:0] a;
    bit [31:0] w;
    bit [31:0] mask;
    int        widx;
    int        off;
    rdata = 32'd0;
    err   = 1'b0;
    a     = addr;
    case (f3)
      3'd0:    begin size = 1; sgn = 1; legal = 1;   end
      3'd1:    begin size = 2; sgn = 1; legal = 1;   end
      3'd2:    begin size = 4; sgn = 0; legal = 1;   end
      3'd4:    begin size = 1; sgn = 0; legal = !we; end
      3'd5:    begin size = 2; sgn = 0; legal = !we; end
      default: begin size = 1; sgn = 0; legal = 0;   end
    endcase
    if (!legal) begin err = 1'b1; return; end
    if (a % size != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
      err = 1'b1;
      return;
`else
      a = a - (a % size);
`endif
    end
    if ((a / 4) >= DEPTH) begin err = 1'b1; return; end
    widx = int'(a / 4);
    off  = int'(a % 4);
    w    = mdl[widx];
    if (we) begin
      for (int i = 0; i < size; i++) w[8*(off+i) +: 8] = wdata[8*i +: 8];
      mdl[widx] = w;
    end else begin
      rdata = w >> (8 * off);
      if (size < 4) begin
        mask  = (32'h1 << (8 * size)) - 32'h1;
        rdata = rdata & mask;
        if (sgn && rdata[8*size-1]) rdata = rdata | ~mask;
      end
    end
  endfunction

  task automatic issue(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] wdata, input bit has_exp, input bit [31:0] er,
                       input bit ee, input bit track);
    int        n = 0;
    int        acc;
    bit [31:0] mr;
    bit        me;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: req_ready stuck at %b, required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (track) begin
      model(we, f3, addr, wdata, mr, me);
      if (has_exp) sbq.push_back('{rdata: er, err: ee, edge_n: acc});
      else         sbq.push_back('{rdata: mr, err: me, edge_n: acc});
    end
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = $urandom_range(0, 1);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || resp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0 || resp_valid) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sbq.size());
    end
  endtask

  // Monitor: latency on first valid, stability while held, data on handshake.
  bit          in_resp   = 1'b0;
  bit          want_rdy  = 1'b0;
  logic [31:0] held_rdata;
  logic        held_err;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst) begin
      in_resp  = 1'b0;
      want_rdy = 1'b0;
    end else begin
      if (want_rdy) begin
        chk("ready_after_resp", 32'(req_ready), 32'd1);
        want_rdy = 1'b0;
      end
      if (resp_valid) begin
        if (!in_resp) begin
          in_resp    = 1'b1;
          held_rdata = resp_rdata;
          held_err   = resp_err;
          if (sbq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_resp: resp_valid=1 with %0d outstanding, required 0",
                     sbq.size());
          end else begin
            chk("resp_latency", 32'(cyc), 32'(sbq[0].edge_n + LATENCY));
          end
        end else begin
          chk("hold_rdata", resp_rdata, held_rdata);
          chk("hold_err", 32'(resp_err), 32'(held_err));
          chk("ready_low_in_resp", 32'(req_ready), 32'd0);
        end
        if (resp_ready) begin
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", 32'(resp_err), 32'(e.err));
          end
          in_resp  = 1'b0;
          want_rdy = 1'b1;
        end
      end
    end
  end

  int          n;
  bit [2:0]    f3;
  bit [31:0]   addr;
  int          r;

  initial begin
    repeat (3) begin
      @(negedge clk);
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_resp_rdata", resp_rdata, 32'd0);
    end
    rst = 1'b1;
    #1 chk("ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 chk("ready_after_release", 32'(req_ready), 32'd1);

    issue(1, 3'd2, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0, 1);
    issue(0, 3'd2, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0, 1);
    issue(1, 3'd0, 32'h11, 32'h80, 1, 32'h0, 0, 1);
    issue(0, 3'd0, 32'h11, 32'h0, 1, 32'hFFFFFF80, 0, 1);
    issue(0, 3'd4, 32'h11, 32'h0, 1, 32'h00000080, 0, 1);
    issue(0, 3'd5, 32'h12, 32'h0, 1, 32'h0000DEAD, 0, 1);
    issue(0, 3'd2, 32'h10, 32'h0, 1, 32'hDEAD80EF, 0, 1);

    drain();
    bp_hold = 1'b1;
    issue(0, 3'd2, 32'h10, 32'h0, 1, 32'hDEAD80EF, 0, 1);
    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_resp_valid", 32'(resp_valid), 32'd1);
    repeat (5) @(negedge clk);
    bp_hold = 1'b0;

    issue(0, 3'd2, DEPTH * 4, 32'h0, 1, 32'h0, 1, 1);
    issue(1, 3'd2, 32'h20, 32'hCAFEF00D, 1, 32'h0, 0, 1);
`ifdef DMEM_MISALIGN_TRAP_EN
    issue(1, 3'd1, 32'h21, 32'h1234, 1, 32'h0, 1, 1);
    issue(0, 3'd2, 32'h20, 32'h0, 1, 32'hCAFEF00D, 0, 1);
`else
    issue(1, 3'd1, 32'h21, 32'h1234, 1, 32'h0, 0, 1);
    issue(0, 3'd2, 32'h20, 32'h0, 1, 32'hCAFE1234, 0, 1);
`endif
    issue(1, 3'd4, 32'h24, 32'h55, 1, 32'h0, 1, 1);
    issue(0, 3'd3, 32'h20, 32'h0, 1, 32'h0, 1, 1);

    for (int w = 0; w < 32; w++) issue(1, 3'd2, 32'(w * 4), $urandom, 0, 32'h0, 0, 1);

    // Reset while the store sits in WAIT: it must never reach the array.
    drain();
    issue(1, 3'd2, 32'h40, 32'h12345678, 0, 32'h0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("midrst_ready_back", 32'(req_ready), 32'd1);
    issue(0, 3'd2, 32'h40, 32'h0, 1, mdl[16], 0, 1);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 4))
        0:       f3 = 3'd0;
        1:       f3 = 3'd1;
        2:       f3 = 3'd2;
        3:       f3 = 3'd4;
        default: f3 = 3'd5;
      endcase
      if (r == 9) f3 = 3'($urandom);
      if ($urandom_range(0, 19) == 0) addr = DEPTH * 4 + $urandom_range(0, 4095);
      else                            addr = $urandom_range(0, 127);
      issue($urandom_range(0, 1), f3, addr, $urandom, 0, 32'h0, 0, 1);
    end

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
